// File: rtl/dram_iaram_tx_pkg.sv
// -----------------------------------------------------------------------------
// dram_iaram_tx_pkg
// Shared definitions for the DRAM -> IARAM beat streamer:
//   - sizing constants that mirror the legacy macro names
//   - Dram_IARAM / Dram_IARAM_indices beat structures seen by the PE
//   - FSM state encodings for dram_iaram_tx
// -----------------------------------------------------------------------------
package dram_iaram_tx_pkg;

    localparam int num_of_data_Dram    = 4;   // entries per beat
    localparam int max_num_K           = 8;   // maximum input channels
    localparam int max_compressed_data = 64;  // maximum compressed entries per channel
    localparam int bits_of_indices     = 4;   // index width

    localparam int k_w = $clog2(max_num_K);

    // Data half of a beat as presented to the PE.
    typedef struct packed {
        logic                                dense;
        logic [num_of_data_Dram-1:0]         valid;
        logic [k_w-1:0]                      input_channel;
        logic [num_of_data_Dram-1:0][15:0]   data;
    } Dram_IARAM;

    // Index half of the same beat.
    typedef struct packed {
        logic [num_of_data_Dram-1:0]                      valid;
        logic [k_w-1:0]                                   input_channel;
        logic [num_of_data_Dram-1:0][bits_of_indices-1:0] indices;
    } Dram_IARAM_indices;

    // Streamer FSM encodings.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/dram_iaram_tx_beat_reg.sv
// -----------------------------------------------------------------------------
// dram_iaram_beat_reg
// One-entry holding register for a beat in flight to the PE.
// Metadata (mask, channel) is captured in the read cycle; the line data is
// taken straight from mem_rdata in the cycle it is valid and captured into a
// local copy at the end of that cycle, so a stalled beat survives the
// memory returning other data.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load            a line read is issued this cycle (mask/channel follow it)
//   consume         the pending beat is taken this cycle
//   flush           drop any pending beat
//   load_mask       per-slot valid mask of the line being read
//   load_ch         channel of the line being read
//   mem_rdata       raw line data, valid the cycle after load
//   load_en         receiver accepting; gates the output valid mask
//   pending         a beat is held
//   valid           pending mask AND load_en
//   channel         channel of the held beat
//   line            slot data of the held beat
// -----------------------------------------------------------------------------
module dram_iaram_beat_reg #(
    parameter int NUM_DATA = 4,
    parameter int IDX_BITS = 4,
    parameter int CH_W     = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   load,
    input  logic                                   consume,
    input  logic                                   flush,
    input  logic [NUM_DATA-1:0]                    load_mask,
    input  logic [CH_W-1:0]                        load_ch,
    input  logic [NUM_DATA-1:0][16+IDX_BITS-1:0]   mem_rdata,
    input  logic                                   load_en,
    output logic                                   pending,
    output logic [NUM_DATA-1:0]                    valid,
    output logic [CH_W-1:0]                        channel,
    output logic [NUM_DATA-1:0][16+IDX_BITS-1:0]   line
);

    logic                                 pending_q;
    logic [NUM_DATA-1:0]                  mask_q;
    logic [CH_W-1:0]                      ch_q;
    logic                                 live_q;   // line data is on mem_rdata this cycle
    logic [NUM_DATA-1:0][16+IDX_BITS-1:0] held_q;

    always_ff @(posedge clk) begin
        // NOTE: the data copy is reset too, because the outputs must read as
        // zero straight after reset, not just carry a cleared valid mask.
        if (rst || flush) begin
            pending_q <= 1'b0;
            mask_q    <= '0;
            ch_q      <= '0;
            live_q    <= 1'b0;
            held_q    <= '0;
        end else begin
            if (live_q) begin
                held_q <= mem_rdata;
            end
            live_q <= load;
            if (load) begin
                pending_q <= 1'b1;
                mask_q    <= load_mask;
                ch_q      <= load_ch;
            end else if (consume) begin
                pending_q <= 1'b0;
                mask_q    <= '0;
            end
        end
    end

    assign pending = pending_q;
    assign valid   = (pending_q && load_en) ? mask_q : '0;
    assign channel = ch_q;
    assign line    = live_q ? mem_rdata : held_q;

endmodule

// File: rtl/dram_iaram_tx.sv
// -----------------------------------------------------------------------------
// dram_iaram_tx
// Streams the compressed entries of channels 0..num_ch-1 from a line-organised
// source memory to the PE, NUM_DATA entries per beat, one beat per cycle while
// the PE holds load_en. Empty channels are skipped, a channel's partial last
// line is sent on its own, and done pulses once the final beat is taken.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a stream (accepted only when idle)
//   num_ch          number of channels to stream, sampled on start
//   ch_len          compressed length of every channel, stable while busy
//   load_en         PE is accepting beats
//   mem_rd_en       line read strobe
//   mem_addr        line address (channel * lines_per_channel + line)
//   mem_rdata       line data, one cycle after mem_rd_en
//   dram_data_out   beat data, valid mask, channel
//   dram_idx_out    beat indices, valid mask, channel
//   busy            stream in progress
//   done            one-cycle completion pulse
// -----------------------------------------------------------------------------
module dram_iaram_tx
    import dram_iaram_tx_pkg::*;
#(
    parameter int NUM_DATA = num_of_data_Dram,
    parameter int MAX_CH   = max_num_K,
    parameter int MAX_ELEM = max_compressed_data,
    parameter int IDX_BITS = bits_of_indices
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              start,
    input  logic [$clog2(MAX_CH):0]                           num_ch,
    input  logic [MAX_CH-1:0][$clog2(MAX_ELEM):0]             ch_len,
    input  logic                                              load_en,
    output logic                                              mem_rd_en,
    output logic [$clog2(MAX_CH*MAX_ELEM/NUM_DATA)-1:0]       mem_addr,
    input  logic [NUM_DATA-1:0][16+IDX_BITS-1:0]              mem_rdata,
    output Dram_IARAM                                         dram_data_out,
    output Dram_IARAM_indices                                 dram_idx_out,
    output logic                                              busy,
    output logic                                              done
);

    localparam int CH_W    = $clog2(MAX_CH);
    localparam int NUM_W   = CH_W + 1;
    localparam int LEN_W   = $clog2(MAX_ELEM) + 1;
    localparam int LINES   = MAX_ELEM / NUM_DATA;
    localparam int ADDR_W  = $clog2(MAX_CH * LINES);
    localparam int NUM_LOG = $clog2(NUM_DATA);

    logic [1:0]       state;
    logic [CH_W-1:0]  ch;
    logic [LEN_W-1:0] elem;   // first entry of the next line to read
    logic [NUM_W-1:0] num_q;

    logic [LEN_W-1:0]    cur_len;
    logic                ch_empty;
    logic                line_last;
    logic                has_later;   // a non-empty channel remains after ch
    logic                any_work;    // some channel below num_ch is non-empty
    logic [NUM_DATA-1:0] rd_mask;
    logic                rd;
    logic                consume;

    logic                                 beat_pending;
    logic [NUM_DATA-1:0]                  beat_valid;
    logic [CH_W-1:0]                      beat_ch;
    logic [NUM_DATA-1:0][16+IDX_BITS-1:0] beat_line;

    assign cur_len   = ch_len[ch];
    assign ch_empty  = (cur_len == '0);
    assign line_last = ({1'b0, elem} + (LEN_W+1)'(NUM_DATA)) >= {1'b0, cur_len};
    assign consume   = beat_pending && load_en;

    // A read may only go out when the beat slot will be free at the edge,
    // which also keeps at most one line in flight.
    assign rd = (state == ST_RUN) && load_en && !ch_empty && (!beat_pending || consume);

    // NOTE: every variable this block drives gets a default before the loop,
    // so no path can leave one unassigned and infer a latch.
    always_comb begin
        has_later = 1'b0;
        any_work  = 1'b0;
        rd_mask   = '0;
        for (int c = 0; c < MAX_CH; c++) begin
            if (c > int'(ch) && c < int'(num_q) && ch_len[c] != '0) begin
                has_later = 1'b1;
            end
            if (c < int'(num_ch) && ch_len[c] != '0) begin
                any_work = 1'b1;
            end
        end
        for (int j = 0; j < NUM_DATA; j++) begin
            rd_mask[j] = ({1'b0, elem} + (LEN_W+1)'(j)) < {1'b0, cur_len};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            ch    <= '0;
            elem  <= '0;
            num_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        num_q <= num_ch;
                        ch    <= '0;
                        elem  <= '0;
                        state <= any_work ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (ch_empty) begin
                        // Skipping costs exactly this one cycle.
                        if (has_later) ch <= ch + CH_W'(1);
                        else           state <= ST_DRAIN;
                    end else if (rd) begin
                        if (line_last) begin
                            elem <= '0;
                            if (has_later) ch <= ch + CH_W'(1);
                            else           state <= ST_DRAIN;
                        end else begin
                            elem <= elem + LEN_W'(NUM_DATA);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!beat_pending || consume) state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    dram_iaram_beat_reg #(
        .NUM_DATA (NUM_DATA),
        .IDX_BITS (IDX_BITS),
        .CH_W     (CH_W)
    ) u_beat (
        .clk       (clk),
        .rst       (rst),
        .load      (rd),
        .consume   (consume),
        .flush     (state == ST_DONE),
        .load_mask (rd_mask),
        .load_ch   (ch),
        .mem_rdata (mem_rdata),
        .load_en   (load_en),
        .pending   (beat_pending),
        .valid     (beat_valid),
        .channel   (beat_ch),
        .line      (beat_line)
    );

    assign mem_rd_en = rd;
    assign mem_addr  = ADDR_W'(ch) * ADDR_W'(LINES) + ADDR_W'(elem >> NUM_LOG);
    assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
    assign done      = (state == ST_DONE);

    always_comb begin
        dram_data_out               = '0;
        dram_idx_out                = '0;
        dram_data_out.dense         = 1'b0;
        dram_data_out.valid         = beat_valid;
        dram_data_out.input_channel = beat_ch;
        dram_idx_out.valid          = beat_valid;
        dram_idx_out.input_channel  = beat_ch;
        for (int j = 0; j < NUM_DATA; j++) begin
            dram_data_out.data[j]   = beat_line[j][IDX_BITS +: 16];
            dram_idx_out.indices[j] = beat_line[j][IDX_BITS-1:0];
        end
    end

endmodule

// File: tb/tb_dram_iaram_tx.sv
// -----------------------------------------------------------------------------
// tb_dram_iaram_tx
// Self-checking bench for dram_iaram_tx: a table of stream scenarios with
// hand-derived beat counts and done cycles, a few hand-written sequences
// (reset mid-stream, highest channel at full length), then random streams.
// Every stream is checked against a reference list of expected reads and
// beats built directly from the channel lengths.
// -----------------------------------------------------------------------------
module tb_dram_iaram_tx;
    import dram_iaram_tx_pkg::*;

    localparam int ND     = 4;
    localparam int MCH    = 8;
    localparam int IB     = 4;
    localparam int LEN_W  = 7;
    localparam int NUM_W  = 4;
    localparam int ADDR_W = 7;
    localparam int LINES  = 16;

    typedef logic [MCH-1:0][LEN_W-1:0] lens_t;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       start;
    logic [NUM_W-1:0]           num_ch;
    lens_t                      ch_len;
    logic                       load_en;
    logic                       mem_rd_en;
    logic [ADDR_W-1:0]          mem_addr;
    logic [ND-1:0][16+IB-1:0]   mem_rdata;
    Dram_IARAM                  dout;
    Dram_IARAM_indices          iout;
    logic                       busy;
    logic                       done;

    always #5 clk = ~clk;

    dram_iaram_tx dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_ch        (num_ch),
        .ch_len        (ch_len),
        .load_en       (load_en),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .dram_data_out (dout),
        .dram_idx_out  (iout),
        .busy          (busy),
        .done          (done)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Source memory image and reference expectations.
    logic [ND-1:0][16+IB-1:0] mem [MCH*LINES];

    typedef struct {
        int            ch;
        logic [ND-1:0] mask;
        int            addr;
    } beat_t;

    int    exp_rd[$];
    beat_t exp_bt[$];

    function automatic lens_t lens8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        lens_t r;
        r[0] = LEN_W'(a0); r[1] = LEN_W'(a1); r[2] = LEN_W'(a2); r[3] = LEN_W'(a3);
        r[4] = LEN_W'(a4); r[5] = LEN_W'(a5); r[6] = LEN_W'(a6); r[7] = LEN_W'(a7);
        return r;
    endfunction

    // Expected reads and beats, straight from the channel lengths.
    task automatic build_model(input int n, input lens_t lens);
        exp_rd.delete();
        exp_bt.delete();
        for (int c = 0; c < n; c++) begin
            int len;
            len = int'(lens[c]);
            for (int e = 0; e < len; e += ND) begin
                beat_t b;
                b.ch   = c;
                b.addr = c * LINES + e / ND;
                for (int j = 0; j < ND; j++) b.mask[j] = (e + j < len);
                exp_rd.push_back(b.addr);
                exp_bt.push_back(b);
            end
        end
    endtask

    // mode 0: load_en always high, 1: random, 2: low on cycles 3..5.
    task automatic run_stream(input int n, input lens_t lens, input int mode, input bit inj,
                              output int beats, output int done_cyc,
                              output int last_rd_cyc, output int last_rd_addr);
        bit prev_rd;
        int prev_addr;
        int last_beat_cyc;
        logic [ND-1:0][15:0]   ed;
        logic [ND-1:0][IB-1:0] ei;
        beat_t b;

        build_model(n, lens);
        beats = 0; done_cyc = -1; last_rd_cyc = -1; last_rd_addr = -1;
        last_beat_cyc = -1; prev_rd = 1'b0; prev_addr = 0;

        @(negedge clk);
        rst = 1'b0; start = 1'b1; num_ch = NUM_W'(n); ch_len = lens; load_en = 1'b1;
        for (int j = 0; j < ND; j++) mem_rdata[j] = 20'($urandom);
        #1;
        check("idle_no_read", mem_rd_en, 0);

        for (int cyc = 1; cyc <= 3000 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            start  = inj && (cyc == 3);
            num_ch = start ? '0 : NUM_W'(n);
            case (mode)
                0:       load_en = 1'b1;
                1:       load_en = ($urandom_range(0, 9) < 7);
                default: load_en = !(cyc >= 3 && cyc <= 5);
            endcase
            if (prev_rd) mem_rdata = mem[prev_addr];
            else for (int j = 0; j < ND; j++) mem_rdata[j] = 20'($urandom);
            #1;
            check("idx_valid_copy", iout.valid, dout.valid);
            if (!load_en) begin
                check("valid_gated", dout.valid, 0);
                check("read_gated", mem_rd_en, 0);
            end
            if (dout.valid != '0) begin
                if (exp_bt.size() == 0) begin
                    check("extra_beat", dout.valid, 0);
                end else begin
                    b = exp_bt.pop_front();
                    beats++;
                    last_beat_cyc = cyc;
                    for (int j = 0; j < ND; j++) begin
                        ed[j] = mem[b.addr][j][16+IB-1:IB];
                        ei[j] = mem[b.addr][j][IB-1:0];
                    end
                    check("beat_mask", dout.valid, b.mask);
                    check("beat_ch", dout.input_channel, b.ch);
                    check("idx_ch", iout.input_channel, b.ch);
                    check("dense", dout.dense, 0);
                    check("beat_data", dout.data, ed);
                    check("beat_idx", iout.indices, ei);
                end
            end
            if (mem_rd_en) begin
                if (exp_rd.size() == 0) check("extra_read", mem_addr, 0);
                else                    check("read_addr", mem_addr, exp_rd.pop_front());
                last_rd_cyc  = cyc;
                last_rd_addr = int'(mem_addr);
            end
            check("busy_level", busy, !done);
            if (done) done_cyc = cyc;
            prev_rd   = mem_rd_en;
            prev_addr = int'(mem_addr);
        end
        start = 1'b0;
        if (done_cyc < 0) check("done_timeout", 0, 1);
        check("beats_missing", exp_bt.size(), 0);
        check("reads_missing", exp_rd.size(), 0);
        if (beats > 0) check("done_after_last_beat", done_cyc, last_beat_cyc + 1);
        else           check("done_empty_stream", done_cyc, 1);
        @(negedge clk);
        #1;
        check("done_one_cycle", done, 0);
        check("idle_not_busy", busy, 0);
    endtask

    typedef struct {
        int    n;
        lens_t lens;
        int    mode;
        bit    inj;
        int    exp_beats;
        int    exp_done;   // -1: timing depends on load_en pattern
    } vec_t;

    vec_t tbl[9];

    initial begin
        int beats, dcyc, lrc, lra;

        rst = 1'b1; start = 1'b0; num_ch = '0; ch_len = '0; load_en = 1'b0; mem_rdata = '0;
        for (int a = 0; a < MCH * LINES; a++)
            for (int j = 0; j < ND; j++) mem[a][j] = 20'($urandom);

        tbl[0] = '{1, lens8(6, 0, 0, 0, 0, 0, 0, 0), 0, 1'b0, 2, 4};
        tbl[1] = '{3, lens8(4, 0, 5, 0, 0, 0, 0, 0), 0, 1'b0, 3, 6};
        tbl[2] = '{0, lens8(9, 9, 0, 0, 0, 0, 0, 0), 0, 1'b0, 0, 1};
        tbl[3] = '{1, lens8(64, 0, 0, 0, 0, 0, 0, 0), 0, 1'b0, 16, 18};
        tbl[4] = '{4, lens8(0, 0, 0, 0, 7, 0, 0, 0), 0, 1'b0, 0, 1};
        tbl[5] = '{8, lens8(1, 2, 3, 4, 5, 6, 7, 8), 0, 1'b1, 12, 14};
        tbl[6] = '{2, lens8(0, 3, 9, 9, 0, 0, 0, 0), 0, 1'b0, 1, 4};
        tbl[7] = '{3, lens8(5, 7, 2, 0, 0, 0, 0, 0), 2, 1'b0, 5, -1};
        tbl[8] = '{8, lens8(64, 64, 64, 64, 64, 64, 64, 64), 1, 1'b1, 128, -1};

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_data_out", dout, 0);
        check("rst_idx_out", iout, 0);

        // Table of stream scenarios.
        for (int i = 0; i < 9; i++) begin
            run_stream(tbl[i].n, tbl[i].lens, tbl[i].mode, tbl[i].inj, beats, dcyc, lrc, lra);
            check($sformatf("tbl%0d_beats", i), beats, tbl[i].exp_beats);
            if (tbl[i].exp_done >= 0) check($sformatf("tbl%0d_done_cycle", i), dcyc, tbl[i].exp_done);
        end

        // Highest channel at full length: reads start after seven skip cycles.
        run_stream(8, lens8(0, 0, 0, 0, 0, 0, 0, 64), 0, 1'b0, beats, dcyc, lrc, lra);
        check("full_last_addr", lra, 127);
        check("full_last_read_cycle", lrc, 23);
        check("full_done_cycle", dcyc, lrc + 2);

        // Reset in RUN with a beat pending.
        @(negedge clk);
        start = 1'b1; num_ch = 4'd2; ch_len = lens8(8, 8, 0, 0, 0, 0, 0, 0); load_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        check("pre_rst_busy", busy, 1);
        check("pre_rst_valid", dout.valid, 4'hf);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_data_out", dout, 0);
        check("mid_rst_idx_out", iout, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rd_en", mem_rd_en, 0);
        check("mid_rst_done", done, 0);
        // Start on the very first cycle after reset releases.
        run_stream(2, lens8(8, 8, 0, 0, 0, 0, 0, 0), 0, 1'b0, beats, dcyc, lrc, lra);
        check("post_rst_beats", beats, 4);

        // Random streams.
        for (int r = 0; r < 6; r++) begin
            lens_t lr;
            int    nr;
            nr = int'($urandom_range(0, 8));
            for (int c = 0; c < MCH; c++)
                lr[c] = ($urandom_range(0, 3) == 0) ? '0 : LEN_W'($urandom_range(1, 64));
            run_stream(nr, lr, 1, 1'b0, beats, dcyc, lrc, lra);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dram_iaram_tx.md
DRAM_IARAM_TX -- requirements
Module: dram_iaram_tx

Interface
REQ-001 Parameter NUM_DATA, default 4: entries per beat (matches `num_of_data_Dram).
REQ-002 Parameter MAX_CH, default 8: maximum input channels (matches `max_num_K).
REQ-003 Parameter MAX_ELEM, default 64: maximum compressed entries per channel, a multiple of NUM_DATA.
REQ-004 Parameter IDX_BITS, default 4: index width (matches `bits_of_indices).
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 start  input  1  one-cycle request to begin streaming all channels.
REQ-008 num_ch  input  clog2(MAX_CH)+1  number of channels to stream, 0..MAX_CH; sampled on accepted start.
REQ-009 ch_len  input  MAX_CH x (clog2(MAX_ELEM)+1)  compressed length per channel; held stable while busy.
REQ-010 load_en  input  1  receiver is accepting beats (PE in load state).
REQ-011 mem_rd_en  output  1  source line read strobe.
REQ-012 mem_addr  output  clog2(MAX_CH*MAX_ELEM/NUM_DATA)  line address = ch*(MAX_ELEM/NUM_DATA) + elem/NUM_DATA.
REQ-013 mem_rdata  input  NUM_DATA x (16+IDX_BITS)  line data, valid exactly one cycle after mem_rd_en; slot j = {data[15:0], index}.
REQ-014 dram_data_out  output  Dram_IARAM  dense, valid[NUM_DATA], input_channel, data[NUM_DATA][16].
REQ-015 dram_idx_out  output  Dram_IARAM_indices  valid[NUM_DATA], input_channel, indices[NUM_DATA][IDX_BITS].
REQ-016 busy  output  1  high from accepted start until done.
REQ-017 done  output  1  one-cycle pulse after the final beat is consumed.

Function
REQ-018 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start (DONE directly if num_ch==0 or every sampled ch_len is 0); RUN->DRAIN after last line read issued; DRAIN->DONE when last beat consumed; DONE->IDLE unconditionally next cycle.
REQ-019 start is ignored outside IDLE.
REQ-020 Channels with ch_len==0 are skipped with no read and no beat; skipping consumes no cycles beyond the channel-advance cycle.
REQ-021 A line read is issued in a cycle only if state==RUN, load_en==1, and the beat register is empty or being consumed that cycle.
REQ-022 Beat register loads from mem_rdata one cycle after each read; slot j valid iff elem_base+j < ch_len[ch]; input_channel = channel of that read.
REQ-023 A beat is consumed in any cycle with load_en==1 while it is pending; sustained load_en gives one beat per cycle after one cycle of read latency.
REQ-024 Output valid bits on both structs equal pending-beat mask AND load_en; with load_en==0 both valid vectors are all zero and the beat holds unchanged.
REQ-025 data/indices/input_channel fields on both structs are identical-beat copies; dense is always 0.
REQ-026 Element counter advances by NUM_DATA per read; at ch_len reached it wraps to 0 and channel increments; last read = final line of last non-empty channel below num_ch.
REQ-027 Partial final line of a channel is emitted alone; next channel starts on a fresh beat (no packing across channels).
REQ-028 done asserts in the cycle after the last beat is consumed; busy deasserts in the same cycle done asserts.

Reset
REQ-029 rst sampled high: next state IDLE, all counters, beat register and outputs zero, busy=0, done=0, mem_rd_en=0, regardless of state; any in-flight read data is discarded.
REQ-030 After rst deasserts the block accepts start on the first cycle.

Structure
REQ-031 Dram_IARAM and Dram_IARAM_indices typedefs and the constants num_of_data_Dram, max_num_K, max_compressed_data, bits_of_indices reside in the shared package, not in this module.
REQ-032 One sub-module, dram_iaram_beat_reg: the one-entry beat holding register with load/consume/flush controls and load_en output gating.

Verification
REQ-033 num_ch=1, ch_len[0]=6, load_en=1 -> two beats: ch0 valid 1111 then 0011, done two cycles after second read.
REQ-034 num_ch=3, ch_len={4,0,5}: beats ch0 1111, ch2 1111, ch2 0001; no read for channel 1.
REQ-035 load_en low for 3 cycles mid-stream -> valid outputs zero, beat and mem_rd_en held, stream resumes with no loss or duplication.
REQ-036 start with num_ch=0 -> done pulse next cycle, no mem_rd_en; start while busy -> ignored.
REQ-037 rst asserted in RUN with beat pending -> next cycle all outputs zero, state IDLE; subsequent start streams from channel 0 element 0.
REQ-038 ch_len[0]=MAX_ELEM -> MAX_ELEM/NUM_DATA full beats, last address = MAX_ELEM/NUM_DATA-1, counter wraps cleanly.
